core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM that sequences the RV32I datapath around the combinational instruction decoder. It fetches an instruction over a ready-based memory handshake and holds it in an instruction register that drives the decoder. It then gates register-file writes, data-memory accesses and PC updates one phase at a time. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

## Interface
- TIMEOUT, 16, max wait cycles for imem/dmem ready; 0 disables timeout
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid (sampled only while imem_req=1)
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, feeds decoder `inst`
- dec_regwrite, dec_s_mem, dec_wb_mux  in  1 each  decoder outputs for current ir
- dec_illegal  in  1  decoder hit default (unknown opcode)
- branch_taken  in  1  branch comparator result, valid in EXEC
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ready  in  1  data access complete (sampled only while dmem_req=1)
- rf_we  out  1  gated register-file write enable
- pc_en  out  1  one-cycle PC update strobe
- pc_sel  out  1  0: PC+4, 1: branch target; valid with pc_en
- instret  out  32  retired-instruction counter
- fault  out  1  sticky trap indicator

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset → IDLE.
- IDLE → FETCH unconditionally.
- FETCH: imem_req=1; on imem_ready, ir<=imem_rdata and go to DECODE; on timeout go to TRAP.
- DECODE: one cycle; dec_illegal=1 → TRAP, else → EXEC.
- EXEC: one cycle; latch pc_sel<=branch_taken. Let is_load = dec_regwrite & ~dec_wb_mux and is_mem = is_load | dec_s_mem.
  - is_mem → MEM.
  - Else dec_regwrite → WB.
  - Else pc_en=1 → FETCH.
- MEM: dmem_req=1, dmem_we=dec_s_mem. On dmem_ready: load → WB; store → pc_en=1 → FETCH. Timeout → TRAP.
- WB: rf_we=1, pc_en=1 for one cycle → FETCH.
- TRAP: fault=1; no requests, no rf_we, no pc_en. Exit only by reset.
- Retire rule: instret increments by 1 in every pc_en cycle. It wraps 0xFFFF_FFFF → 0.
- pc_sel is forced to 0 for non-branch instructions: pc_sel = branch_taken is sampled only when dec_regwrite=0 and dec_s_mem=0.
- Wait timer: counts consecutive FETCH or MEM cycles without ready and clears on every state change. Timeout fires when the count reaches TIMEOUT with ready still low, i.e. the (TIMEOUT+1)-th waiting cycle. Ready arriving on that same cycle wins over timeout.
- Counter width: $clog2(TIMEOUT+1). The timer is inert when TIMEOUT=0.

## Timing
- Reset values (asynchronous): state=IDLE, ir=0, instret=0, fault=0, pc_sel=0. All combinational strobes (imem_req, dmem_req, dmem_we, rf_we, pc_en) are 0 because they decode from state.
- First imem_req is asserted 1 cycle after rst deasserts.
- Latency from the first FETCH cycle to pc_en, with ready returned in the first request cycle:
  - branch/no-write: 3 cycles
  - ALU/LUI/JAL: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each wait cycle adds 1.
- Ready is sampled at the clock edge while req is high. A ready pulse while req is low is ignored.
- Reset mid-operation abandons the current instruction immediately: requests drop asynchronously and instret is cleared.

## Structure
- Package core_pkg holds:
  - the state typedef: enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP}
  - the opcode localparams shared with the decoder
  - the TIMEOUT default
- Sub-module wait_timer (clk, rst, run, hit, timeout) is shared by FETCH and MEM. `run` is high in FETCH/MEM, and a state change clears the count.
- State register, ir, pc_sel, instret and fault live in core_sequencer. Output decode is a single always_comb on state.

## Test plan
- ALU instruction 0x00208033, imem_ready immediate, dec_regwrite=1, dec_wb_mux=1:
  - imem_req seen 1 cycle after reset
  - rf_we and pc_en coincide 4 cycles after FETCH entry
  - instret goes 0→1
- Load then store, dmem_ready delayed 3 cycles each:
  - load: dmem_we=0, rf_we after ready, total 8 cycles
  - store: dmem_we=1, no rf_we, pc_en on ready cycle
  - instret=2
- Branch with branch_taken=1 in EXEC: pc_en with pc_sel=1 at cycle 3 and no rf_we. A following ALU instruction gives pc_sel=0.
- TIMEOUT=4, imem_ready held low: TRAP entered on the 5th wait cycle, fault=1 stays high, no further requests. Ready on the 5th cycle instead → DECODE and no fault.
- dec_illegal=1 in DECODE → TRAP, fault=1, instret unchanged. rst pulse mid-MEM → dmem_req drops immediately, then IDLE→FETCH and instret=0.
- Preload instret to 0xFFFF_FFFF (force) and retire one instruction → instret=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
// Holds the state encoding, the decoder's opcode set and the default wait limit.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  // Default cap on how long a fetch or data access may wait for ready.
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Consecutive-wait counter shared by the FETCH and MEM phases.
// Fires on the (TIMEOUT+1)-th waiting cycle; ready on that cycle wins.
module wait_timer
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hit,
  output logic timeout
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign timeout = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

      logic [CW-1:0] r_cnt;

      // Every exit from a waiting state is a hit or a timeout, so clearing on
      // those (and whenever not running) clears the count on each state change.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (!run || hit || timeout) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign timeout = run && !hit && (r_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM around the RV32I decoder: fetch into ir, then gate
// memory, register writes and PC updates one phase at a time.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_regwrite,
  input  logic        dec_s_mem,
  input  logic        dec_wb_mux,
  input  logic        dec_illegal,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic        pc_en,
  output logic        pc_sel,
  output logic [31:0] instret,
  output logic        fault
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_instret;
  logic        r_pc_sel;
  logic        r_fault;

  logic w_is_load;
  logic w_is_mem;
  logic w_br_sel;
  logic w_run;
  logic w_hit;
  logic w_timeout;

  assign w_is_load = dec_regwrite & ~dec_wb_mux;
  assign w_is_mem  = w_is_load | dec_s_mem;
  assign w_br_sel  = branch_taken & ~dec_regwrite & ~dec_s_mem;
  assign w_run     = (r_state == FETCH) || (r_state == MEM);
  assign w_hit     = (r_state == FETCH) ? imem_ready : dmem_ready;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (w_run),
    .hit    (w_hit),
    .timeout(w_timeout)
  );

  // NOTE: every output and next state gets a default first, so no path infers a latch.
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_next = DECODE;
        end else if (w_timeout) begin
          w_next = TRAP;
        end
      end
      DECODE: w_next = dec_illegal ? TRAP : EXEC;
      EXEC: begin
        if (w_is_mem) begin
          w_next = MEM;
        end else if (dec_regwrite) begin
          w_next = WB;
        end else begin
          pc_en  = 1'b1;
          w_next = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_s_mem;
        if (dmem_ready) begin
          if (w_is_load) begin
            w_next = WB;
          end else begin
            pc_en  = 1'b1;
            w_next = FETCH;
          end
        end else if (w_timeout) begin
          w_next = TRAP;
        end
      end
      WB: begin
        rf_we  = 1'b1;
        pc_en  = 1'b1;
        w_next = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ir      <= '0;
      r_instret <= '0;
      r_pc_sel  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem_ready) begin
        r_ir <= imem_rdata;
      end
      if (r_state == EXEC) begin
        r_pc_sel <= w_br_sel;
      end
      if (pc_en) begin
        r_instret <= r_instret + 32'd1;
      end
      if (w_next == TRAP) begin
        r_fault <= 1'b1;
      end
    end
  end

  // A branch retires inside EXEC, before r_pc_sel has captured the select,
  // so EXEC forwards the live value.
  assign pc_sel  = (r_state == EXEC) ? w_br_sel : r_pc_sel;
  assign ir      = r_ir;
  assign instret = r_instret;
  assign fault   = r_fault;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes expected retire records,
// a negedge monitor pops and compares them on every pc_en.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic        dec_regwrite = 1'b0;
  logic        dec_s_mem = 1'b0;
  logic        dec_wb_mux = 1'b0;
  logic        dec_illegal = 1'b0;
  logic        branch_taken = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic        rf_we;
  logic        pc_en;
  logic        pc_sel;
  logic [31:0] instret;
  logic        fault;

  always #5 clk = ~clk;

  core_sequencer #(
    .TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .dec_regwrite(dec_regwrite),
    .dec_s_mem   (dec_s_mem),
    .dec_wb_mux  (dec_wb_mux),
    .dec_illegal (dec_illegal),
    .branch_taken(branch_taken),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .rf_we       (rf_we),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .instret     (instret),
    .fault       (fault)
  );

  // mem: 0 no data access, 1 read, 2 write. lat: cycles from FETCH entry to pc_en inclusive.
  typedef struct {
    logic [31:0] ir;
    int          rf_we;
    int          pc_sel;
    int          mem;
    int          lat;
    logic [31:0] pre;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   start = 0;
  int   mem_seen = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (imem_req && !prev_req) start = cyc;
    prev_req = imem_req;
    if (dmem_req && dmem_ready) mem_seen = dmem_we ? 2 : 1;
    if (rf_we) check("rf_we_with_pc_en", {31'd0, pc_en}, 32'd1);
    if (pc_en) begin
      if (exp_q.size() == 0) begin
        check("queue_depth_at_retire", exp_q.size(), 1);
      end else begin
        e_mon = exp_q.pop_front();
        check("ir", ir, e_mon.ir);
        check("rf_we", {31'd0, rf_we}, e_mon.rf_we);
        check("pc_sel", {31'd0, pc_sel}, e_mon.pc_sel);
        check("mem_kind", mem_seen, e_mon.mem);
        check("latency", cyc - start + 1, e_mon.lat);
        check("instret_pre", instret, e_mon.pre);
      end
      mem_seen = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
  endtask

  // Return ready after `waits` request cycles; ready stays up until next_cycle.
  task automatic serve(input bit imem, input int waits);
    int seen = 0;
    for (int t = 0; t < 40; t++) begin
      if (imem ? imem_req : dmem_req) begin
        if (seen == waits) begin
          if (imem) imem_ready = 1'b1;
          else dmem_ready = 1'b1;
          return;
        end
        seen++;
      end
      next_cycle();
    end
    check(imem ? "imem_req_seen" : "dmem_req_seen", {31'd0, imem ? imem_req : dmem_req}, 32'd1);
  endtask

  task automatic set_dec(input logic [31:0] inst, input logic rw, input logic sm,
                         input logic wbm, input logic br, input logic ill);
    imem_rdata   = inst;
    dec_regwrite = rw;
    dec_s_mem    = sm;
    dec_wb_mux   = wbm;
    branch_taken = br;
    dec_illegal  = ill;
  endtask

  task automatic run_instr(input logic [31:0] inst, input logic rw, input logic sm,
                           input logic wbm, input logic br, input int iw, input int dw,
                           input int lat, input int erf, input int esel, input int emem,
                           input logic [31:0] pre);
    set_dec(inst, rw, sm, wbm, br, 1'b0);
    exp_q.push_back('{inst, erf, esel, emem, lat, pre});
    serve(1'b1, iw);
    next_cycle();
    if (sm || (rw && !wbm)) serve(1'b0, dw);
    #1;
    for (int t = 0; t < 20 && !pc_en; t++) next_cycle();
    check("pc_en_seen", {31'd0, pc_en}, 32'd1);
    next_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_dec(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ir", ir, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_pc_sel", {31'd0, pc_sel}, 32'd0);
    check("rst_strobes", {27'd0, imem_req, dmem_req, dmem_we, rf_we, pc_en}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("idle_no_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    check("req_one_cycle_after_reset", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic check_quiet(input string name);
    logic bad = 1'b0;
    for (int t = 0; t < 6; t++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #1;
      bad = bad | imem_req | dmem_req | pc_en | rf_we;
      next_cycle();
    end
    check(name, {31'd0, bad}, 32'd0);
    check({name, "_fault"}, {31'd0, fault}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    do_reset();

    //        inst           rw    sm    wbm   br    iw dw lat rf sel mem pre
    run_instr(32'h00208033, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 4, 1, 0, 0, 32'd0);  // add
    run_instr(32'h0000A103, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 8, 1, 0, 1, 32'd1);  // lw
    run_instr(32'h0020A023, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 7, 0, 0, 2, 32'd2);  // sw
    run_instr(32'h00208463, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 3, 0, 1, 0, 32'd3);  // beq taken
    run_instr(32'h002081B3, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 4, 1, 0, 0, 32'd4);  // add, br ignored
    run_instr(32'h00209463, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 5, 0, 0, 0, 32'd5);  // bne not taken
    run_instr(32'h123450B7, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0, 8, 1, 0, 0, 32'd6);  // lui, ready on last wait
    check("instret_after_seven", instret, 32'd7);
    check("no_fault_ready_at_limit", {31'd0, fault}, 32'd0);

    // Illegal opcode traps from DECODE without retiring.
    set_dec(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    serve(1'b1, 0);
    next_cycle();
    check("decode_no_fault_yet", {31'd0, fault}, 32'd0);
    next_cycle();
    check("illegal_fault", {31'd0, fault}, 32'd1);
    check("illegal_instret", instret, 32'd7);
    check("illegal_ir", ir, 32'hFFFF_FFFF);
    check_quiet("illegal_trap_quiet");

    // Fetch timeout: TIMEOUT=4 gives five FETCH cycles, then TRAP.
    do_reset();
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (imem_req) cnt++;
      else break;
      next_cycle();
    end
    check("fetch_wait_cycles", cnt, 5);
    check("timeout_fault", {31'd0, fault}, 32'd1);
    check_quiet("timeout_trap_quiet");

    // Reset in the middle of a data access.
    do_reset();
    run_instr(32'h00208033, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 4, 1, 0, 0, 32'd0);
    set_dec(32'h0000A103, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    serve(1'b1, 0);
    next_cycle();
    for (int t = 0; t < 10 && !dmem_req; t++) next_cycle();
    check("reached_mem", {31'd0, dmem_req}, 32'd1);
    check("instret_before_reset", instret, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("dmem_req_drops_async", {31'd0, dmem_req}, 32'd0);
    check("instret_cleared_async", instret, 32'd0);
    do_reset();

    // Counter wrap: preload all-ones, retire one branch.
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    run_instr(32'h00208463, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 0, 32'hFFFF_FFFF);
    check("instret_wrap", instret, 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
    $fatal(1, "bench timed out");
  end

endmodule
